// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline hazard/flush controller: forwarding selects and stage writer info.
// Register indices in stage_wr_t are held at a fixed maximum width and zero-extended by users.
package pipe_ctrl_pkg;

  localparam int REG_IDX_MAX_W = 8;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_EX  = 2'b01,
    FWD_MEM = 2'b10,
    FWD_WB  = 2'b11
  } fwd_sel_t;

  typedef struct packed {
    logic                     valid;
    logic                     wb_en;
    logic [REG_IDX_MAX_W-1:0] rd;
  } stage_wr_t;

  // Register 0 is hard-wired zero and never creates a dependency.
  function automatic logic stage_match(input stage_wr_t s, input logic [REG_IDX_MAX_W-1:0] x);
    return s.valid & s.wb_en & (s.rd == x) & (x != '0);
  endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Per-register pending bits and in-flight counter for long-latency matrix ops, plus a sticky
// error flag for completions that match nothing outstanding. All state updates on posedge clk.
module hazard_scoreboard
  import pipe_ctrl_pkg::*;
#(
  parameter int NUM_REGS    = 32,
  parameter int REG_IDX_W   = $clog2(NUM_REGS),
  parameter int MAX_MTX_OPS = 4,
  parameter int CNT_W       = $clog2(MAX_MTX_OPS + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_issue,
  input  logic                 i_issue_wb_en,
  input  logic [REG_IDX_W-1:0] i_issue_rd,
  input  logic                 i_cmpl_valid,
  input  logic [REG_IDX_W-1:0] i_cmpl_rd,
  output logic [NUM_REGS-1:0]  o_pending,
  output logic [CNT_W-1:0]     o_cnt,
  output logic                 o_err
);

  logic [NUM_REGS-1:0] r_pending;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_err;

  logic [NUM_REGS-1:0] w_set_mask;
  logic [NUM_REGS-1:0] w_clr_mask;
  logic                w_cmpl_bad;
  logic                w_cnt_full;
  logic                w_cnt_empty;

  assign w_cnt_full  = (r_cnt == CNT_W'(MAX_MTX_OPS));
  assign w_cnt_empty = (r_cnt == '0);

  always_comb begin
    w_set_mask = '0;
    w_clr_mask = '0;
    if (i_issue && i_issue_wb_en && (i_issue_rd != '0))
      w_set_mask[i_issue_rd] = 1'b1;
    if (i_cmpl_valid)
      w_clr_mask[i_cmpl_rd] = 1'b1;
  end

  assign w_cmpl_bad = i_cmpl_valid & (~r_pending[i_cmpl_rd] | w_cnt_empty);

  // Set is applied after clear so a forced same-index set+clear leaves the bit pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= '0;
      r_cnt     <= '0;
      r_err     <= 1'b0;
    end else begin
      r_pending <= (r_pending & ~w_clr_mask) | w_set_mask;
      if (i_issue && !i_cmpl_valid && !w_cnt_full)
        r_cnt <= r_cnt + CNT_W'(1);
      else if (i_cmpl_valid && !i_issue && !w_cnt_empty)
        r_cnt <= r_cnt - CNT_W'(1);
      if (w_cmpl_bad)
        r_err <= 1'b1;
    end
  end

  assign o_pending = r_pending;
  assign o_cnt     = r_cnt;
  assign o_err     = r_err;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/flush controller beside decode: scoreboard, matrix credit, RAW stalls and redirect flush.
// Define HAZARD_FWD_EN to reduce RAW stalls to load-use and drive operand forwarding selects.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int NUM_REGS    = 32,
  parameter int REG_IDX_W   = $clog2(NUM_REGS),
  parameter int MAX_MTX_OPS = 4,
  parameter int CNT_W       = $clog2(MAX_MTX_OPS + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_dec_valid,
  input  logic [REG_IDX_W-1:0] i_dec_rs1,
  input  logic [REG_IDX_W-1:0] i_dec_rs2,
  input  logic                 i_dec_rs1_used,
  input  logic                 i_dec_rs2_used,
  input  logic [REG_IDX_W-1:0] i_dec_rd,
  input  logic                 i_dec_wb_en,
  input  logic                 i_dec_is_matrix,
  input  logic                 i_ex_valid,
  input  logic                 i_ex_wb_en,
  input  logic                 i_ex_is_load,
  input  logic [REG_IDX_W-1:0] i_ex_rd,
  input  logic                 i_mem_valid,
  input  logic                 i_mem_wb_en,
  input  logic [REG_IDX_W-1:0] i_mem_rd,
  input  logic                 i_wb_valid,
  input  logic                 i_wb_wb_en,
  input  logic [REG_IDX_W-1:0] i_wb_rd,
  input  logic                 i_branch_redirect,
  input  logic                 i_mtx_ready,
  input  logic                 i_mtx_cmpl_valid,
  input  logic [REG_IDX_W-1:0] i_mtx_cmpl_rd,
  output logic                 o_fetch_stall,
  output logic                 o_decode_stall,
  output logic                 o_fetch_flush,
  output logic                 o_decode_flush,
  output logic                 o_execute_flush,
  output logic                 o_mtx_issue,
  output logic [CNT_W-1:0]     o_mtx_outstanding,
  output logic [NUM_REGS-1:0]  o_sb_pending,
  output logic                 o_sb_err,
  output logic [1:0]           o_fwd_sel_rs1,
  output logic [1:0]           o_fwd_sel_rs2
);

  stage_wr_t                w_ex, w_mem, w_wb;
  logic [REG_IDX_MAX_W-1:0] w_rs1_x, w_rs2_x;
  logic                     w_ex1, w_ex2, w_mem1, w_mem2, w_wb1, w_wb2;
  logic                     w_hz_sb, w_hz_raw, w_hz_mtx, w_stall, w_issue;
  fwd_sel_t                 w_fwd1, w_fwd2;

  assign w_ex    = '{valid: i_ex_valid,  wb_en: i_ex_wb_en,  rd: REG_IDX_MAX_W'(i_ex_rd)};
  assign w_mem   = '{valid: i_mem_valid, wb_en: i_mem_wb_en, rd: REG_IDX_MAX_W'(i_mem_rd)};
  assign w_wb    = '{valid: i_wb_valid,  wb_en: i_wb_wb_en,  rd: REG_IDX_MAX_W'(i_wb_rd)};
  assign w_rs1_x = REG_IDX_MAX_W'(i_dec_rs1);
  assign w_rs2_x = REG_IDX_MAX_W'(i_dec_rs2);

  assign w_ex1  = stage_match(w_ex,  w_rs1_x);
  assign w_ex2  = stage_match(w_ex,  w_rs2_x);
  assign w_mem1 = stage_match(w_mem, w_rs1_x);
  assign w_mem2 = stage_match(w_mem, w_rs2_x);
  assign w_wb1  = stage_match(w_wb,  w_rs1_x);
  assign w_wb2  = stage_match(w_wb,  w_rs2_x);

  // Sources and destination checked against the scoreboard cover both RAW and WAW on matrix results.
  assign w_hz_sb = i_dec_valid &
                   ((i_dec_rs1_used & o_sb_pending[i_dec_rs1]) |
                    (i_dec_rs2_used & o_sb_pending[i_dec_rs2]) |
                    (i_dec_wb_en    & o_sb_pending[i_dec_rd]));

  assign w_hz_mtx = i_dec_valid & i_dec_is_matrix &
                    ((o_mtx_outstanding == CNT_W'(MAX_MTX_OPS)) | ~i_mtx_ready);

`ifdef HAZARD_FWD_EN
  // A load in EX has no data yet, so it can neither forward nor be bypassed.
  function automatic fwd_sel_t fwd_pick(input logic ex, input logic mem, input logic wb,
                                        input logic ex_load);
    if (ex && !ex_load) return FWD_EX;
    else if (mem)       return FWD_MEM;
    else if (wb)        return FWD_WB;
    else                return FWD_RF;
  endfunction

  assign w_hz_raw = i_dec_valid & i_ex_is_load &
                    ((i_dec_rs1_used & w_ex1) | (i_dec_rs2_used & w_ex2));
  assign w_fwd1   = fwd_pick(w_ex1, w_mem1, w_wb1, i_ex_is_load);
  assign w_fwd2   = fwd_pick(w_ex2, w_mem2, w_wb2, i_ex_is_load);
`else
  logic w_unused_ex_is_load;

  assign w_unused_ex_is_load = i_ex_is_load;
  assign w_hz_raw = i_dec_valid &
                    ((i_dec_rs1_used & (w_ex1 | w_mem1 | w_wb1)) |
                     (i_dec_rs2_used & (w_ex2 | w_mem2 | w_wb2)));
  assign w_fwd1   = FWD_RF;
  assign w_fwd2   = FWD_RF;
`endif

  // A redirect squashes decode, so it overrides every stall and blocks issue.
  assign w_stall = (w_hz_sb | w_hz_raw | w_hz_mtx) & ~i_branch_redirect;
  assign w_issue = i_dec_valid & i_dec_is_matrix & ~w_stall & ~i_branch_redirect;

  assign o_fetch_stall   = w_stall;
  assign o_decode_stall  = w_stall;
  assign o_fetch_flush   = i_branch_redirect;
  assign o_decode_flush  = i_branch_redirect;
  assign o_execute_flush = w_stall | i_branch_redirect;
  assign o_mtx_issue     = w_issue;
  assign o_fwd_sel_rs1   = w_fwd1;
  assign o_fwd_sel_rs2   = w_fwd2;

  hazard_scoreboard #(
    .NUM_REGS    (NUM_REGS),
    .REG_IDX_W   (REG_IDX_W),
    .MAX_MTX_OPS (MAX_MTX_OPS),
    .CNT_W       (CNT_W)
  ) u_sb (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_issue       (w_issue),
    .i_issue_wb_en (i_dec_wb_en),
    .i_issue_rd    (i_dec_rd),
    .i_cmpl_valid  (i_mtx_cmpl_valid),
    .i_cmpl_rd     (i_mtx_cmpl_rd),
    .o_pending     (o_sb_pending),
    .o_cnt         (o_mtx_outstanding),
    .o_err         (o_sb_err)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: each step queues its expected outputs, and a
// negedge monitor pops and compares them against the DUT.
module tb_pipeline_hazard_ctrl;

`ifdef HAZARD_FWD_EN
  localparam logic FWD = 1'b1;
`else
  localparam logic FWD = 1'b0;
`endif

  typedef struct packed {
    logic        fs;
    logic        ds;
    logic        ff;
    logic        df;
    logic        ef;
    logic        iss;
    logic [2:0]  cnt;
    logic        err;
    logic [1:0]  f1;
    logic [1:0]  f2;
    logic [31:0] pend;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        dec_valid, dec_rs1_used, dec_rs2_used, dec_wb_en, dec_is_matrix;
  logic [4:0]  dec_rs1, dec_rs2, dec_rd, ex_rd, mem_rd, wb_rd, cmpl_rd;
  logic        ex_valid, ex_wb_en, ex_is_load, mem_valid, mem_wb_en, wb_valid, wb_wb_en;
  logic        branch_redirect, mtx_ready, cmpl_valid;
  logic        fetch_stall, decode_stall, fetch_flush, decode_flush, execute_flush, mtx_issue;
  logic [2:0]  mtx_outstanding;
  logic [31:0] sb_pending;
  logic        sb_err;
  logic [1:0]  fwd_sel_rs1, fwd_sel_rs2;

  int    checks = 0;
  int    errors = 0;
  exp_t  exp_q[$];
  string name_q[$];

  always #5 clk = ~clk;

  pipeline_hazard_ctrl dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .i_dec_valid       (dec_valid),
    .i_dec_rs1         (dec_rs1),
    .i_dec_rs2         (dec_rs2),
    .i_dec_rs1_used    (dec_rs1_used),
    .i_dec_rs2_used    (dec_rs2_used),
    .i_dec_rd          (dec_rd),
    .i_dec_wb_en       (dec_wb_en),
    .i_dec_is_matrix   (dec_is_matrix),
    .i_ex_valid        (ex_valid),
    .i_ex_wb_en        (ex_wb_en),
    .i_ex_is_load      (ex_is_load),
    .i_ex_rd           (ex_rd),
    .i_mem_valid       (mem_valid),
    .i_mem_wb_en       (mem_wb_en),
    .i_mem_rd          (mem_rd),
    .i_wb_valid        (wb_valid),
    .i_wb_wb_en        (wb_wb_en),
    .i_wb_rd           (wb_rd),
    .i_branch_redirect (branch_redirect),
    .i_mtx_ready       (mtx_ready),
    .i_mtx_cmpl_valid  (cmpl_valid),
    .i_mtx_cmpl_rd     (cmpl_rd),
    .o_fetch_stall     (fetch_stall),
    .o_decode_stall    (decode_stall),
    .o_fetch_flush     (fetch_flush),
    .o_decode_flush    (decode_flush),
    .o_execute_flush   (execute_flush),
    .o_mtx_issue       (mtx_issue),
    .o_mtx_outstanding (mtx_outstanding),
    .o_sb_pending      (sb_pending),
    .o_sb_err          (sb_err),
    .o_fwd_sel_rs1     (fwd_sel_rs1),
    .o_fwd_sel_rs2     (fwd_sel_rs2)
  );

  always @(negedge clk) begin
    exp_t  e;
    exp_t  g;
    string n;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n = name_q.pop_front();
      g = {fetch_stall, decode_stall, fetch_flush, decode_flush, execute_flush, mtx_issue,
           mtx_outstanding, sb_err, fwd_sel_rs1, fwd_sel_rs2, sb_pending};
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL %s: got fs%b ds%b ff%b df%b ef%b iss%b cnt%0d err%b f1=%b f2=%b pend=%h ; want fs%b ds%b ff%b df%b ef%b iss%b cnt%0d err%b f1=%b f2=%b pend=%h",
                 n, g.fs, g.ds, g.ff, g.df, g.ef, g.iss, g.cnt, g.err, g.f1, g.f2, g.pend,
                 e.fs, e.ds, e.ff, e.df, e.ef, e.iss, e.cnt, e.err, e.f1, e.f2, e.pend);
      end
    end
  end

  task automatic idle();
    dec_valid = 0; dec_rs1 = 0; dec_rs2 = 0; dec_rs1_used = 0; dec_rs2_used = 0;
    dec_rd = 0; dec_wb_en = 0; dec_is_matrix = 0;
    ex_valid = 0; ex_wb_en = 0; ex_is_load = 0; ex_rd = 0;
    mem_valid = 0; mem_wb_en = 0; mem_rd = 0;
    wb_valid = 0; wb_wb_en = 0; wb_rd = 0;
    branch_redirect = 0; mtx_ready = 1; cmpl_valid = 0; cmpl_rd = 0;
  endtask

  task automatic mtx(input logic [4:0] rd);
    idle();
    dec_valid = 1; dec_is_matrix = 1; dec_wb_en = 1; dec_rd = rd;
  endtask

  task automatic alu(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
    idle();
    dec_valid = 1; dec_rs1 = rs1; dec_rs2 = rs2; dec_rs1_used = 1; dec_rs2_used = 1;
    dec_wb_en = 1; dec_rd = rd;
  endtask

  task automatic cmpl(input logic [4:0] rd);
    cmpl_valid = 1; cmpl_rd = rd;
  endtask

  // stl covers both stalls, fl both fetch/decode flushes.
  task automatic step(input string nm, input logic stl, input logic fl, input logic ef,
                      input logic iss, input int cnt, input logic err, input logic [1:0] f1,
                      input logic [1:0] f2, input logic [31:0] pend);
    exp_t e;
    e = {stl, stl, fl, fl, ef, iss, 3'(cnt), err, f1, f2, pend};
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;

    step("reset_state", 0,0,0,0, 0,0, 0,0, 32'h0);

    // Reset in the middle of outstanding work.
    mtx(5);  step("rst_iss_r5", 0,0,0,1, 0,0, 0,0, 32'h0);
    mtx(6);  step("rst_iss_r6", 0,0,0,1, 1,0, 0,0, 32'h20);
    idle();  step("mid_op",     0,0,0,0, 2,0, 0,0, 32'h60);
    rst_n = 0;
    step("rst_async", 0,0,0,0, 0,0, 0,0, 32'h0);
    rst_n = 1;
    step("rst_rel0", 0,0,0,0, 0,0, 0,0, 32'h0);
    step("rst_rel1", 0,0,0,0, 0,0, 0,0, 32'h0);

    // Scoreboard RAW on a matrix result.
    mtx(5);          step("sb_iss_r5",    0,0,0,1, 0,0, 0,0, 32'h0);
    alu(5, 0, 10);   step("sb_stall0",    1,0,1,0, 1,0, 0,0, 32'h20);
                     step("sb_stall1",    1,0,1,0, 1,0, 0,0, 32'h20);
    cmpl(5);         step("sb_cmpl_cyc",  1,0,1,0, 1,0, 0,0, 32'h20);
    alu(5, 0, 10);   step("sb_release",   0,0,0,0, 0,0, 0,0, 32'h0);

    // Credit limit.
    mtx(1);  step("cr_iss1", 0,0,0,1, 0,0, 0,0, 32'h0);
    mtx(2);  step("cr_iss2", 0,0,0,1, 1,0, 0,0, 32'h2);
    mtx(3);  step("cr_iss3", 0,0,0,1, 2,0, 0,0, 32'h6);
    mtx(4);  step("cr_iss4", 0,0,0,1, 3,0, 0,0, 32'he);
    mtx(8);  step("cr_full", 1,0,1,0, 4,0, 0,0, 32'h1e);
    cmpl(2); step("cr_cmpl", 1,0,1,0, 4,0, 0,0, 32'h1e);
    mtx(8);  step("cr_iss5", 0,0,0,1, 3,0, 0,0, 32'h1a);
    idle(); cmpl(1); step("dr_r1", 0,0,0,0, 4,0, 0,0, 32'h11a);
    idle(); cmpl(3); step("dr_r3", 0,0,0,0, 3,0, 0,0, 32'h118);
    idle(); cmpl(4); step("dr_r4", 0,0,0,0, 2,0, 0,0, 32'h110);
    idle(); cmpl(8); step("dr_r8", 0,0,0,0, 1,0, 0,0, 32'h100);
    idle();          step("dr_done", 0,0,0,0, 0,0, 0,0, 32'h0);

    // Simultaneous issue and completion keeps the count.
    mtx(3);          step("both_iss3",  0,0,0,1, 0,0, 0,0, 32'h0);
    mtx(4); cmpl(3); step("both_cyc",   0,0,0,1, 1,0, 0,0, 32'h8);
    idle(); cmpl(4); step("both_after", 0,0,0,0, 1,0, 0,0, 32'h10);
    idle();          step("both_drain", 0,0,0,0, 0,0, 0,0, 32'h0);

    // Pipeline RAW against EX/MEM/WB writers.
    alu(7, 0, 11); ex_valid = 1; ex_wb_en = 1; ex_rd = 7;
    step("raw_ex", !FWD,0,!FWD,0, 0,0, FWD ? 2'b01 : 2'b00, 0, 32'h0);
    ex_is_load = 1;
    step("raw_ex_load", 1,0,1,0, 0,0, 0,0, 32'h0);
    alu(7, 0, 11); mem_valid = 1; mem_wb_en = 1; mem_rd = 7;
    step("raw_mem", !FWD,0,!FWD,0, 0,0, FWD ? 2'b10 : 2'b00, 0, 32'h0);
    ex_valid = 1; ex_wb_en = 1; ex_rd = 7;
    step("raw_ex_mem_prio", !FWD,0,!FWD,0, 0,0, FWD ? 2'b01 : 2'b00, 0, 32'h0);
    alu(0, 12, 11); wb_valid = 1; wb_wb_en = 1; wb_rd = 12;
    step("raw_wb_rs2", !FWD,0,!FWD,0, 0,0, 0, FWD ? 2'b11 : 2'b00, 32'h0);
    alu(7, 0, 11); dec_rs1_used = 0; ex_valid = 1; ex_wb_en = 1; ex_rd = 7;
    step("raw_unused_src", 0,0,0,0, 0,0, FWD ? 2'b01 : 2'b00, 0, 32'h0);
    alu(7, 0, 11); ex_valid = 1; ex_wb_en = 0; ex_rd = 7;
    step("raw_no_wb", 0,0,0,0, 0,0, 0,0, 32'h0);

    // Redirect overrides a scoreboard stall and blocks issue.
    mtx(5);          step("rd_iss_r5",   0,0,0,1, 0,0, 0,0, 32'h0);
    alu(5, 0, 10); branch_redirect = 1;
    step("rd_over_sb", 0,1,1,0, 1,0, 0,0, 32'h20);
    mtx(11); branch_redirect = 1;
    step("rd_no_issue", 0,1,1,0, 1,0, 0,0, 32'h20);
    idle(); cmpl(5); step("rd_cmpl",     0,0,0,0, 1,0, 0,0, 32'h20);
    idle();          step("rd_drain",    0,0,0,0, 0,0, 0,0, 32'h0);

    // Accelerator not ready.
    mtx(6); mtx_ready = 0;
    step("mtx_not_ready", 1,0,1,0, 0,0, 0,0, 32'h0);

    // Bogus completion sets sticky error; register 0 never hazards.
    idle(); cmpl(9); step("err_cmpl", 0,0,0,0, 0,0, 0,0, 32'h0);
    idle();          step("err_sticky", 0,0,0,0, 0,1, 0,0, 32'h0);
    alu(0, 0, 0); ex_valid = 1; ex_wb_en = 1; ex_rd = 0; ex_is_load = 1;
    mem_valid = 1; mem_wb_en = 1; mem_rd = 0;
    step("r0_no_hazard", 0,0,0,0, 0,1, 0,0, 32'h0);
    idle();          step("err_hold", 0,0,0,0, 0,1, 0,0, 32'h0);

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d entries left, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
